// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: reads imem at the PC, resolves jump/branch/halt locally,
// issues other words downstream over valid/ready. FETCH_COND_BRANCH_EN enables opcode 4'hE as BZ.
module fetch_sequencer #(
   parameter int ADDR_W  = 9,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc_addr,
   output logic               pc_enable,
   output logic               pc_jmpen,
   output logic [15:0]        pc_jmpaddr,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic               imem_en,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               zero_flag,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic               halted
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_ISSUE  = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [ADDR_W-1:0]    ipc_q, ipc_d;
   logic [3:0]           opcode;
   logic [ADDR_W-1:0]    target;

   assign opcode = imem_rdata[INSTR_W-1 -: 4];
   assign target = imem_rdata[ADDR_W-1:0];

`ifndef FETCH_COND_BRANCH_EN
   logic zero_flag_unused;
   assign zero_flag_unused = zero_flag;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         instr_q <= '0;
         ipc_q   <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      ipc_d       = ipc_q;
      pc_enable   = 1'b0;
      pc_jmpen    = 1'b0;
      pc_jmpaddr  = '0;
      imem_en     = 1'b0;
      imem_addr   = '0;
      instr_valid = 1'b0;
      halted      = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            imem_en   = 1'b1;
            imem_addr = pc_addr;
            ipc_d     = pc_addr;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            // Jumps and branches are resolved here and never reach the downstream stage.
            if (imem_rdata == '0) begin
               state_d = S_HALT;
            end else if (opcode == 4'hF) begin
               pc_jmpen   = 1'b1;
               pc_jmpaddr = 16'(target);
               state_d    = S_FETCH;
            end
`ifdef FETCH_COND_BRANCH_EN
            else if (opcode == 4'hE) begin
               if (zero_flag) begin
                  pc_jmpen   = 1'b1;
                  pc_jmpaddr = 16'(target);
               end else begin
                  pc_enable  = 1'b1;
               end
               state_d = S_FETCH;
            end
`endif
            else begin
               instr_d = imem_rdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            instr_valid = 1'b1;
            if (instr_ready) begin
               pc_enable = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   assign instr_out = instr_q;
   assign instr_pc  = ipc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a program-level reference model predicts the event
// stream (issue / jump / increment / halt); a negedge monitor pops and compares it.
module tb_fetch_sequencer;
   localparam int K_ISSUE = 0, K_JMP = 1, K_INC = 2, K_HALT = 3;

   typedef struct {
      int         kind;
      logic [15:0] w;
      logic [8:0]  a;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [8:0]  pc_m;
   logic        pc_enable, pc_jmpen, imem_en, zero_flag, instr_valid, instr_ready, halted;
   logic [15:0] pc_jmpaddr, rdata_m, instr_out;
   logic [8:0]  imem_addr, instr_pc;

   logic [15:0] mem    [0:511];
   logic        zf_tab [0:511];
   ev_t         exp_q[$];
   int          acc_cyc[$];
   int          checks = 0, errors = 0, cyc = 0;
   bit          rnd_ready = 0, force_lo = 0;
   int          lo_cnt = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.ADDR_W(9), .INSTR_W(16)) dut (
      .clk(clk), .rst(rst_n), .pc_addr(pc_m), .pc_enable(pc_enable), .pc_jmpen(pc_jmpen),
      .pc_jmpaddr(pc_jmpaddr), .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(rdata_m),
      .zero_flag(zero_flag), .instr_out(instr_out), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted)
   );

   // Environment: program counter and synchronous instruction memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        pc_m <= '0;
      else if (pc_jmpen) pc_m <= pc_jmpaddr[8:0];
      else if (pc_enable) pc_m <= pc_m + 9'd1;
   end
   always_ff @(posedge clk) if (imem_en) rdata_m <= mem[imem_addr];
   always_ff @(posedge clk) cyc <= cyc + 1;
   assign zero_flag = zf_tab[pc_m];

   task automatic chk(string nm, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference model: walk the program as an instruction-set interpreter.
   task automatic build_model(int maxev);
      logic [8:0]  pc;
      logic [15:0] w;
      pc = '0;
      for (int n = 0; n < maxev; n++) begin
         w = mem[pc];
         if (w == 16'h0) begin
            exp_q.push_back('{kind: K_HALT, w: 16'h0, a: 9'h0});
            return;
         end
         if (w[15:12] == 4'hF) begin
            exp_q.push_back('{kind: K_JMP, w: {7'b0, w[8:0]}, a: pc});
            pc = w[8:0];
         end
`ifdef FETCH_COND_BRANCH_EN
         else if (w[15:12] == 4'hE) begin
            if (zf_tab[pc]) begin
               exp_q.push_back('{kind: K_JMP, w: {7'b0, w[8:0]}, a: pc});
               pc = w[8:0];
            end else begin
               exp_q.push_back('{kind: K_INC, w: 16'h0, a: pc});
               pc = pc + 9'd1;
            end
         end
`endif
         else begin
            exp_q.push_back('{kind: K_ISSUE, w: w, a: pc});
            pc = pc + 9'd1;
         end
      end
   endtask

   // Monitor
   logic        prev_hold = 0, prev_halt = 0;
   logic [15:0] prev_out = 0;
   logic [8:0]  prev_pc = 0;
   always @(negedge clk) begin : mon
      ev_t got;
      ev_t e;
      bit  has;
      if (!rst_n) begin
         prev_hold = 0;
         prev_halt = 0;
      end else begin
         has = 0;
         got = '{kind: 0, w: 16'h0, a: 9'h0};
         chk("pulse_excl", pc_enable & pc_jmpen, 0);
         if (!pc_jmpen) chk("jmpaddr_zero", pc_jmpaddr, 0);
         if (imem_en) chk("imem_addr", imem_addr, pc_m);
         if (halted) chk("halt_quiet", {imem_en, pc_enable, pc_jmpen}, 0);
         if (prev_hold) begin
            chk("valid_hold", instr_valid, 1);
            chk("out_stable", instr_out, prev_out);
            chk("pc_stable", instr_pc, prev_pc);
         end
         if (instr_valid && instr_ready) begin
            got = '{kind: K_ISSUE, w: instr_out, a: instr_pc};
            has = 1;
            acc_cyc.push_back(cyc);
            chk("issue_pc_enable", pc_enable, 1);
         end else if (pc_jmpen) begin
            got = '{kind: K_JMP, w: pc_jmpaddr, a: pc_m};
            has = 1;
         end else if (pc_enable) begin
            got = '{kind: K_INC, w: 16'h0, a: pc_m};
            has = 1;
         end else if (halted && !prev_halt) begin
            got = '{kind: K_HALT, w: 16'h0, a: 9'h0};
            has = 1;
         end
         if (has) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_event kind=%0d word=%0h addr=%0h expected=none", got.kind, got.w, got.a);
            end else begin
               e = exp_q.pop_front();
               chk("ev_kind", got.kind, e.kind);
               chk("ev_word", got.w, e.w);
               chk("ev_addr", got.a, e.a);
            end
         end
         prev_hold = instr_valid && !instr_ready;
         prev_out  = instr_out;
         prev_pc   = instr_pc;
         prev_halt = halted;
      end
   end

   // Downstream ready driver
   initial begin
      instr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (force_lo) instr_ready = 1'b0;
         else if (!rnd_ready) instr_ready = 1'b1;
         else if (lo_cnt > 0) begin
            lo_cnt--;
            instr_ready = 1'b0;
         end else if ($urandom_range(0, 19) == 0) begin
            lo_cnt = 4;
            instr_ready = 1'b0;
         end else instr_ready = ($urandom_range(0, 2) != 0);
      end
   end

   task automatic clear_prog();
      for (int i = 0; i < 512; i++) begin
         mem[i] = 16'h0;
         zf_tab[i] = 1'b0;
      end
   endtask

   task automatic random_prog();
      logic [15:0] w;
      int r;
      for (int i = 0; i < 512; i++) begin
         r = $urandom_range(0, 99);
         w = 16'($urandom);
         if (r < 4) w = 16'h0;
         else if (r < 20) w[15:12] = 4'hF;
         else if (r < 35) w[15:12] = 4'hE;
         else begin
            if (w[15:13] == 3'b111) w[15] = 1'b0;
            if (w == 16'h0) w = 16'h0001;
         end
         mem[i] = w;
         zf_tab[i] = 1'($urandom);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      exp_q.delete();
      acc_cyc.delete();
   endtask

   // Releases reset, waits for the predicted event stream to drain, then reasserts reset.
   task automatic run_phase(string nm, bit ends_halt);
      int t;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         #3;
         t++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout pending=%0d expected=0", nm, exp_q.size());
      end
      if (ends_halt) begin
         repeat (6) @(posedge clk);
         #3;
         chk({nm, "_halted"}, halted, 1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clear_prog();
      repeat (2) @(posedge clk);
      #3;
      chk("rst_valid", instr_valid, 0);
      chk("rst_out", instr_out, 0);
      chk("rst_pulses", {pc_enable, pc_jmpen, imem_en, halted}, 0);
      chk("rst_addrs", {pc_jmpaddr, imem_addr, instr_pc}, 0);

      // Two issues, jump to 5, halt there; ready held high.
      mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hF005; mem[5] = 16'h0000;
      build_model(20);
      acc_cyc.delete();
      run_phase("basic", 1);
      chk("basic_accepts", acc_cyc.size(), 2);
      if (acc_cyc.size() == 2) chk("basic_spacing", acc_cyc[1] - acc_cyc[0], 3);
      do_reset();

      // Wrap-around from 0x1FF to 0x000.
      clear_prog();
      mem[0] = 16'hF1FE; mem[9'h1FE] = 16'h2222; mem[9'h1FF] = 16'h3333;
      build_model(9);
      run_phase("wrap", 0);
      do_reset();

      // Conditional branch: taken at 0, not taken at 0x10, halt at 0x11.
      clear_prog();
      mem[0] = 16'hE010; zf_tab[0] = 1'b1;
      mem[9'h10] = 16'hE020; mem[9'h11] = 16'h0000;
      build_model(10);
      run_phase("bz", 1);
      do_reset();

      // Reset asserted while an instruction waits for acceptance.
      clear_prog();
      mem[0] = 16'h4321;
      force_lo = 1;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int t = 0; t < 20 && !instr_valid; t++) begin
         @(posedge clk);
         #3;
      end
      chk("pre_rst_valid", instr_valid, 1);
      chk("pre_rst_out", instr_out, 16'h4321);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", instr_valid, 0);
      chk("async_rst_out", instr_out, 0);
      chk("async_rst_pc", instr_pc, 0);
      force_lo = 0;
      do_reset();

      // Random programs with random downstream back-pressure.
      rnd_ready = 1;
      for (int p = 0; p < 8; p++) begin
         random_prog();
         build_model(60);
         run_phase("rand", 0);
         do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
